// File: rtl/mvu_pkg.sv
// Shared MVU array constants and types used by the controller-side read path.
package mvu_pkg;

  localparam int NMVU       = 8;
  localparam int BDBANKA    = 15;
  localparam int BDBANKW    = 64;
  localparam int BLEN       = 16;
  localparam int RDC_RDLAT  = 2;
  localparam int RDC_FDEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rdc_reader_state_t;

endpackage

// File: rtl/mvu_rdc_fifo.sv
// Small synchronous FIFO buffering returned read words until the sink takes them.
// A push alongside a pop is accepted even when the FIFO is full.
module mvu_rdc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (int'(count_q) == DEPTH);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mvu_rdc_reader.sv
// Bulk readback engine for the MVU data memories: issues grant-qualified reads
// for one command at a time and streams the returned words out in address order.
module mvu_rdc_reader
  import mvu_pkg::*;
#(
  parameter int NMVU    = mvu_pkg::NMVU,
  parameter int BDBANKA = mvu_pkg::BDBANKA,
  parameter int BDBANKW = mvu_pkg::BDBANKW,
  parameter int BLEN    = mvu_pkg::BLEN,
  parameter int RDLAT   = mvu_pkg::RDC_RDLAT,
  parameter int FDEPTH  = mvu_pkg::RDC_FDEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [$clog2(NMVU)-1:0]   cmd_mvu,
  input  logic [BDBANKA-1:0]        cmd_addr,
  input  logic [BLEN-1:0]           cmd_len,
  output logic [NMVU-1:0]           rdc_en,
  input  logic [NMVU-1:0]           rdc_grnt,
  output logic [NMVU*BDBANKA-1:0]   rdc_addr,
  input  logic [NMVU*BDBANKW-1:0]   rdc_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BDBANKW-1:0]        out_word,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int MW  = $clog2(NMVU);
  localparam int CW  = $clog2(FDEPTH) + 1;
  localparam int IFW = $clog2(RDLAT + 1);

  rdc_reader_state_t state_q, state_d;
  logic [MW-1:0]      sel_q, sel_d;
  logic [BDBANKA-1:0] addr_q, addr_d;
  logic [BLEN-1:0]    issue_rem_q, issue_rem_d;
  logic [BLEN-1:0]    pop_rem_q, pop_rem_d;
  logic [RDLAT-1:0]   pipe_q, pipe_d;
  logic               done_q, done_d;

  logic [IFW-1:0]     in_flight;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [BDBANKW-1:0] fifo_head;
  logic               credit_ok;
  logic               issue_req;
  logic               take;
  logic               push;
  logic               pop;

  // Every granted read owns a FIFO slot from grant until pop, so the FIFO cannot overflow.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RDLAT; i++) begin
      in_flight = in_flight + IFW'(pipe_q[i]);
    end
  end

  assign credit_ok = !fifo_full && ((int'(in_flight) + int'(fifo_count)) < FDEPTH);
  assign issue_req = (state_q == ISSUE) && (issue_rem_q != '0) && credit_ok;
  assign take      = issue_req && rdc_grnt[sel_q];
  assign push      = pipe_q[RDLAT-1];
  assign pop       = !fifo_empty && out_ready;

  always_comb begin
    rdc_en   = '0;
    rdc_addr = '0;
    if (issue_req) begin
      rdc_en[sel_q] = 1'b1;
      rdc_addr[int'(sel_q)*BDBANKA +: BDBANKA] = addr_q;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = !fifo_empty;
  assign out_word  = fifo_empty ? '0 : fifo_head;
  assign out_last  = !fifo_empty && (pop_rem_q == BLEN'(1));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    pop_rem_d   = pop_rem_q;
    done_d      = 1'b0;
    pipe_d      = RDLAT'({pipe_q, take});
    if (pop) pop_rem_d = pop_rem_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          sel_d       = cmd_mvu;
          addr_d      = cmd_addr;
          issue_rem_d = cmd_len;
          pop_rem_d   = cmd_len;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (take) begin
          addr_d      = addr_q + 1'b1;
          issue_rem_d = issue_rem_q - 1'b1;
          if (issue_rem_q == BLEN'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (pop_rem_q == BLEN'(1)) && (in_flight == '0)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      issue_rem_q <= '0;
      pop_rem_q   <= '0;
      pipe_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      issue_rem_q <= issue_rem_d;
      pop_rem_q   <= pop_rem_d;
      pipe_q      <= pipe_d;
      done_q      <= done_d;
    end
  end

  mvu_rdc_fifo #(
    .DEPTH (FDEPTH),
    .WIDTH (BDBANKW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (rdc_word[int'(sel_q)*BDBANKW +: BDBANKW]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: doc/mvu_rdc_reader.md
Name: mvu_rdc_reader

Overview:
- Bulk-readback engine that drives the controller read side of the MVU data memories (rdc_en / rdc_addr / rdc_grnt / rdc_word) across all NMVU lanes.
- Takes one command (MVU index, start address, word count) at a time and issues grant-qualified reads.
- Buffers the returned words in a small credit-managed FIFO and presents them as a valid/ready stream with a last flag.
- Sits between the host/DMA side of the accelerator and the MVU array; it is the reader counterpart of the controller write path.

Parameters:
- NMVU, 8, number of MVUs.
- BDBANKA, 15, data-memory word address width.
- BDBANKW, 64, data-memory word width.
- BLEN, 16, command length field width.
- RDLAT, 2, cycles from a granted request to its rdc_word being valid (≥1).
- FDEPTH, 4, output FIFO depth (power of two, ≥ RDLAT+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_mvu  in  $clog2(NMVU)  target MVU.
- cmd_addr  in  BDBANKA  first word address.
- cmd_len  in  BLEN  number of words to read.
- rdc_en  out  NMVU  per-MVU read request.
- rdc_grnt  in  NMVU  per-MVU grant, same cycle as rdc_en.
- rdc_addr  out  NMVU*BDBANKA  per-MVU read address.
- rdc_word  in  NMVU*BDBANKW  per-MVU read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink ready.
- out_word  out  BDBANKW  stream data.
- out_last  out  1  final word of the command.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; every output is 0 except cmd_ready=1.
  - FIFO emptied, response pipe cleared, counters zeroed.
  - Reset mid-command discards all in-flight and buffered words; no done pulse.
- IDLE:
  - cmd_ready=1.
  - On accept: latch mvu, addr, len into sel/cur_addr/remaining; set issued_cnt=0.
  - If len≠0 → ISSUE. If len=0 → no reads, done=1 next cycle, stay IDLE.
- ISSUE:
  - Asserts rdc_en[sel]=1 only when remaining_issue>0 and credits available, where in_flight + fifo_count < FDEPTH.
  - rdc_addr lane sel = cur_addr; all other lanes and enables are 0.
  - Request is taken only when rdc_en[sel]&rdc_grnt[sel]. On take: cur_addr+1, wrapping modulo 2^BDBANKA (0x7FFF→0x0000); remaining_issue−1.
  - No grant → hold address and retry next cycle. Grant on a non-selected lane is ignored.
  - When remaining_issue reaches 0 → DRAIN.
- Response pipe:
  - RDLAT-deep shift of the taken bit.
  - At the pipe output, capture rdc_word lane sel into the FIFO. Credits guarantee the FIFO never overflows.
- Stream:
  - out_valid = FIFO non-empty; out_word = FIFO head; pop on out_valid&out_ready.
  - out_last=1 on the head word when it is the last word of the command.
  - The sink may stall indefinitely. Issue pauses once credits hit 0 and resumes the cycle after a pop frees a credit.
- DRAIN:
  - Waits for in_flight=0 and the last word popped.
  - done=1 for one cycle in the cycle after the final pop → IDLE.
- Ordering and concurrency:
  - busy=1 in ISSUE/DRAIN; cmd_ready=0 in ISSUE/DRAIN.
  - Commands never overlap and words are returned in address order.
  - Simultaneous FIFO push and pop on a full FIFO is legal; occupancy is unchanged.
- Throughput:
  - 1 word/cycle sustained with continuous grant and out_ready=1 and FDEPTH ≥ RDLAT+1.
  - First out_valid appears RDLAT+1 cycles after the first grant.

Decomposition:
- Add to mvu_pkg:
  - RDC_RDLAT constant.
  - rdc_reader_state_t enum {IDLE, ISSUE, DRAIN}.
  - BLEN, reusing NMVU/BDBANKA/BDBANKW.
- One sub-module: mvu_rdc_fifo (synchronous FIFO, DEPTH/WIDTH params, count output, push/pop/full/empty).

Test Plan:
- Command mvu=3, addr=0x0010, len=8, grant tied 1, out_ready=1, memory word = {mvu,addr} → 8 words 0x0010..0x0017 from lane 3 only; out_last on the 8th; done pulses once; rdc_en[7:0] only bit 3.
- mvu=0, addr=0x7FFE, len=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001 in order.
- Grant pattern 1,0,0,1,… on mvu=5, len=6 → address held during denials; exactly 6 unique addresses; no duplicate or missing words.
- out_ready=0 for 20 cycles, len=10 → at most FDEPTH granted reads outstanding/buffered; rdc_en deasserts; after release all 10 words arrive intact.
- len=0 → done pulse the cycle after accept; rdc_en never asserted; out_valid stays 0.
- rst_n low for 1 cycle mid-command (after 3 of 8 words) → all outputs return to reset values immediately; no done; a fresh len=2 command completes normally.
